// File: rtl/cond_exec_ctrl_if.sv
// Execute-stage conditional-execution bus.
// The master side drives the decoded Execute instruction: valid, stall,
// condition, flag-write mask, ALU flags and the raw write enables.
// The slave side (cond_exec_ctrl) returns the gated write enables, the raw
// condition result, the NZCV register, the squash-window indicator and the
// executed/annulled event counters.
interface cond_exec_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             ValidE;
  logic             StallE;
  logic [3:0]       CondE;
  logic [1:0]       FlagWriteE;
  logic [3:0]       ALUFlags;
  logic             RegWriteE;
  logic             MemWriteE;
  logic             PCSrcE;

  logic             RegWriteG;
  logic             MemWriteG;
  logic             PCSrcG;
  logic             CondExE;
  logic [3:0]       Flags;
  logic             Shadow;
  logic [CNT_W-1:0] ExecCount;
  logic [CNT_W-1:0] AnnulCount;

  modport master (
    output ValidE, StallE, CondE, FlagWriteE, ALUFlags,
           RegWriteE, MemWriteE, PCSrcE,
    input  RegWriteG, MemWriteG, PCSrcG, CondExE, Flags, Shadow,
           ExecCount, AnnulCount
  );

  modport slave (
    input  ValidE, StallE, CondE, FlagWriteE, ALUFlags,
           RegWriteE, MemWriteE, PCSrcE,
    output RegWriteG, MemWriteG, PCSrcG, CondExE, Flags, Shadow,
           ExecCount, AnnulCount
  );
endinterface

// File: rtl/cond_exec_ctrl.sv
// Execute-stage conditional-execution controller.
// Holds the NZCV flag register, evaluates the Execute condition field against
// it, gates register/memory/PC writes, squashes SHADOW_CYCLES advancing
// Execute slots after a taken redirect, and counts committed and annulled
// instructions with saturating counters.
// Ports:
//   clk     - system clock, rising edge
//   reset_n - asynchronous active-low reset
//   bus     - slave side of cond_exec_ctrl_if (decoded Execute inputs in,
//             gated enables / flags / shadow / counters out)
module cond_exec_ctrl #(
  parameter int SHADOW_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input logic            clk,
  input logic            reset_n,
  cond_exec_ctrl_if.slave bus
);

  typedef enum logic {RUN = 1'b0, SHADOW = 1'b1} state_e;

  localparam logic [3:0]       SHADOW_INIT = 4'(SHADOW_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       flags_q, flags_d;
  logic [CNT_W-1:0] exec_q, exec_d;
  logic [CNT_W-1:0] annul_q, annul_d;

  logic cond_pass;
  logic advance;
  logic in_shadow;
  logic commit;
  logic annul;

  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, ge;
    n  = f[3];
    z  = f[2];
    cf = f[1];
    v  = f[0];
    ge = (n == v);
    case (c)
      4'b0000: cond_eval = z;
      4'b0001: cond_eval = !z;
      4'b0010: cond_eval = cf;
      4'b0011: cond_eval = !cf;
      4'b0100: cond_eval = n;
      4'b0101: cond_eval = !n;
      4'b0110: cond_eval = v;
      4'b0111: cond_eval = !v;
      4'b1000: cond_eval = cf & !z;
      4'b1001: cond_eval = !(cf & !z);
      4'b1010: cond_eval = ge;
      4'b1011: cond_eval = !ge;
      4'b1100: cond_eval = !z & ge;
      4'b1101: cond_eval = !(!z & ge);
      4'b1110: cond_eval = 1'b1;
      default: cond_eval = 1'b0;   // 1111 never executes
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    sat_inc = (x == CNT_MAX) ? x : x + 1'b1;
  endfunction

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: bubbles consume window slots, stalls freeze them
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (bus.PCSrcE && commit) begin
          state_d = SHADOW;
          cnt_d   = SHADOW_INIT;
        end
      end
      SHADOW: begin
        if (advance) begin
          if (cnt_q == 4'd1) begin
            state_d = RUN;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Output logic: commit and annul are mutually exclusive by construction
  always_comb begin
    cond_pass = cond_eval(bus.CondE, flags_q);
    advance   = !bus.StallE;
    in_shadow = (state_q == SHADOW);
    commit    = bus.ValidE & advance & cond_pass & !in_shadow;
    annul     = bus.ValidE & advance & (!cond_pass | in_shadow);
  end

  always_comb begin
    flags_d = flags_q;
    if (commit) begin
      if (bus.FlagWriteE[1]) flags_d[3:2] = bus.ALUFlags[3:2];
      if (bus.FlagWriteE[0]) flags_d[1:0] = bus.ALUFlags[1:0];
    end
    exec_d  = commit ? sat_inc(exec_q)  : exec_q;
    annul_d = annul  ? sat_inc(annul_q) : annul_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_q <= 4'd0;
      exec_q  <= '0;
      annul_q <= '0;
    end else begin
      flags_q <= flags_d;
      exec_q  <= exec_d;
      annul_q <= annul_d;
    end
  end

  assign bus.RegWriteG  = bus.RegWriteE & commit;
  assign bus.MemWriteG  = bus.MemWriteE & commit;
  assign bus.PCSrcG     = bus.PCSrcE & commit;
  assign bus.CondExE    = cond_pass;
  assign bus.Flags      = flags_q;
  assign bus.Shadow     = in_shadow;
  assign bus.ExecCount  = exec_q;
  assign bus.AnnulCount = annul_q;

endmodule

// File: tb/tb_cond_exec_ctrl.sv
module tb_cond_exec_ctrl;

  localparam int SC    = 2;
  localparam int CNT_W = 6;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  int checks   = 0;
  int failures = 0;

  cond_exec_ctrl_if #(.CNT_W(CNT_W)) bus ();

  cond_exec_ctrl #(.SHADOW_CYCLES(SC), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Condition model: pairs of codes share a base test, odd code inverts it.
  function automatic bit cond_model(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cc, v, base;
    n = f[3]; z = f[2]; cc = f[1]; v = f[0];
    if (c == 4'hF) return 1'b0;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cc;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cc && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  // Behavioural model state
  logic [3:0] m_flags;
  int         m_left;   // squash slots remaining, 0 = running
  int         m_exec;
  int         m_annul;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_flags = 4'd0;
      m_left  = 0;
      m_exec  = 0;
      m_annul = 0;
    end else if (!bus.StallE) begin
      bit pass;
      int old_left;
      pass     = cond_model(bus.CondE, m_flags);
      old_left = m_left;
      if (old_left > 0) m_left = old_left - 1;
      if (bus.ValidE) begin
        if (old_left == 0 && pass) begin
          if (m_exec < CMAX) m_exec++;
          if (bus.FlagWriteE[1]) m_flags[3:2] = bus.ALUFlags[3:2];
          if (bus.FlagWriteE[0]) m_flags[1:0] = bus.ALUFlags[1:0];
          if (bus.PCSrcE) m_left = SC;
        end else begin
          if (m_annul < CMAX) m_annul++;
        end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    bit pass, com;
    pass = cond_model(bus.CondE, m_flags);
    com  = bus.ValidE && !bus.StallE && pass && (m_left == 0);
    chk("m_RegWriteG",  32'(bus.RegWriteG),  32'(bus.RegWriteE && com));
    chk("m_MemWriteG",  32'(bus.MemWriteG),  32'(bus.MemWriteE && com));
    chk("m_PCSrcG",     32'(bus.PCSrcG),     32'(bus.PCSrcE && com));
    chk("m_CondExE",    32'(bus.CondExE),    32'(pass));
    chk("m_Flags",      32'(bus.Flags),      32'(m_flags));
    chk("m_Shadow",     32'(bus.Shadow),     32'(m_left > 0));
    chk("m_ExecCount",  32'(bus.ExecCount),  32'(m_exec));
    chk("m_AnnulCount", 32'(bus.AnnulCount), 32'(m_annul));
  end

  task automatic set_in(input logic v, input logic s, input logic [3:0] c,
                        input logic [1:0] fw, input logic [3:0] alu,
                        input logic rw, input logic mw, input logic pc);
    bus.ValidE     = v;
    bus.StallE     = s;
    bus.CondE      = c;
    bus.FlagWriteE = fw;
    bus.ALUFlags   = alu;
    bus.RegWriteE  = rw;
    bus.MemWriteE  = mw;
    bus.PCSrcE     = pc;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    set_in(0, 0, 4'h0, 2'b00, 4'h0, 0, 0, 0);
    tick; tick;
    chk("rst_flags", 32'(bus.Flags), 32'h0);
    chk("rst_exec",  32'(bus.ExecCount), 32'h0);
    chk("rst_shadow", 32'(bus.Shadow), 32'h0);
    reset_n = 1'b1;

    // NE passes with Z=0, EQ fails
    set_in(1, 0, 4'h1, 2'b00, 4'h0, 1, 0, 0); #1;
    chk("ne_regwr", 32'(bus.RegWriteG), 32'h1);
    chk("ne_condex", 32'(bus.CondExE), 32'h1);
    tick;
    chk("ne_exec", 32'(bus.ExecCount), 32'h1);
    set_in(1, 0, 4'h0, 2'b00, 4'h0, 1, 0, 0); #1;
    chk("eq_regwr", 32'(bus.RegWriteG), 32'h0);
    tick;
    chk("eq_annul", 32'(bus.AnnulCount), 32'h1);

    // Flag setting, full and partial masks
    set_in(1, 0, 4'hE, 2'b11, 4'h4, 0, 0, 0); tick;
    chk("fset_full", 32'(bus.Flags), 32'h4);
    set_in(1, 0, 4'h0, 2'b00, 4'h0, 1, 0, 0); #1;
    chk("eq_after_z", 32'(bus.RegWriteG), 32'h1);
    tick;
    set_in(1, 0, 4'hE, 2'b10, 4'hB, 0, 0, 0); tick;
    chk("fset_nz", 32'(bus.Flags), 32'h8);
    chk("exec4", 32'(bus.ExecCount), 32'h4);

    // Taken branch and two squashed slots
    set_in(1, 0, 4'hE, 2'b00, 4'h0, 0, 0, 1); #1;
    chk("br_pcsrc", 32'(bus.PCSrcG), 32'h1);
    tick;
    chk("br_shadow", 32'(bus.Shadow), 32'h1);
    chk("br_exec", 32'(bus.ExecCount), 32'h5);
    set_in(1, 0, 4'hE, 2'b00, 4'h0, 0, 1, 0); #1;
    chk("sq1_memwr", 32'(bus.MemWriteG), 32'h0);
    tick;
    chk("sq1_shadow", 32'(bus.Shadow), 32'h1);
    chk("sq1_annul", 32'(bus.AnnulCount), 32'h2);
    tick;
    chk("sq2_shadow", 32'(bus.Shadow), 32'h0);
    chk("sq2_annul", 32'(bus.AnnulCount), 32'h3);
    chk("third_memwr", 32'(bus.MemWriteG), 32'h1);
    tick;
    chk("third_exec", 32'(bus.ExecCount), 32'h6);

    // Stall in the middle of the window
    set_in(1, 0, 4'hE, 2'b00, 4'h0, 0, 0, 1); tick;
    set_in(1, 0, 4'hE, 2'b00, 4'h0, 0, 1, 0); tick;
    set_in(1, 1, 4'hE, 2'b00, 4'h0, 0, 1, 0);
    tick; tick; tick;
    chk("stl_shadow", 32'(bus.Shadow), 32'h1);
    chk("stl_annul", 32'(bus.AnnulCount), 32'h4);
    chk("stl_exec", 32'(bus.ExecCount), 32'h7);
    set_in(1, 0, 4'hE, 2'b00, 4'h0, 0, 1, 0); tick;
    chk("stl_end_shadow", 32'(bus.Shadow), 32'h0);
    chk("stl_end_annul", 32'(bus.AnnulCount), 32'h5);

    // Stall with a passing redirect and flag write: nothing happens
    set_in(1, 1, 4'hE, 2'b11, 4'hF, 0, 0, 1); #1;
    chk("stlpc_pcsrc", 32'(bus.PCSrcG), 32'h0);
    tick;
    chk("stlpc_shadow", 32'(bus.Shadow), 32'h0);
    chk("stlpc_exec", 32'(bus.ExecCount), 32'h7);
    chk("stlpc_flags", 32'(bus.Flags), 32'h8);

    // Signed comparisons with N=V
    set_in(1, 0, 4'hE, 2'b11, 4'h9, 0, 0, 0); tick;
    chk("f1001", 32'(bus.Flags), 32'h9);
    set_in(0, 0, 4'hA, 2'b00, 4'h0, 0, 0, 0); #1; chk("ge", 32'(bus.CondExE), 32'h1);
    set_in(0, 0, 4'hB, 2'b00, 4'h0, 0, 0, 0); #1; chk("lt", 32'(bus.CondExE), 32'h0);
    set_in(0, 0, 4'hC, 2'b00, 4'h0, 0, 0, 0); #1; chk("gt", 32'(bus.CondExE), 32'h1);
    set_in(0, 0, 4'hD, 2'b00, 4'h0, 0, 0, 0); #1; chk("le", 32'(bus.CondExE), 32'h0);
    set_in(0, 0, 4'hF, 2'b00, 4'h0, 0, 0, 0); #1; chk("nv", 32'(bus.CondExE), 32'h0);

    // Failing flag-setter leaves flags alone
    set_in(1, 0, 4'h0, 2'b11, 4'h4, 1, 0, 0); #1;
    chk("fail_regwr", 32'(bus.RegWriteG), 32'h0);
    tick;
    chk("fail_flags", 32'(bus.Flags), 32'h9);
    chk("fail_annul", 32'(bus.AnnulCount), 32'h6);

    // Asynchronous reset in the middle of a window
    set_in(1, 0, 4'hE, 2'b00, 4'h0, 0, 0, 1); tick;
    chk("ar_shadow_pre", 32'(bus.Shadow), 32'h1);
    chk("ar_exec_pre", 32'(bus.ExecCount), 32'h9);
    set_in(1, 0, 4'hE, 2'b00, 4'h0, 0, 1, 0);
    #3 reset_n = 1'b0;
    #1;
    chk("ar_shadow", 32'(bus.Shadow), 32'h0);
    chk("ar_flags", 32'(bus.Flags), 32'h0);
    chk("ar_exec", 32'(bus.ExecCount), 32'h0);
    chk("ar_annul", 32'(bus.AnnulCount), 32'h0);
    chk("ar_memwr", 32'(bus.MemWriteG), 32'h1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    chk("rel_memwr", 32'(bus.MemWriteG), 32'h1);
    tick;
    chk("rel_exec", 32'(bus.ExecCount), 32'h1);

    // Saturation of the commit counter
    set_in(1, 0, 4'hE, 2'b00, 4'h0, 1, 0, 0);
    repeat (CMAX + 6) tick;
    chk("sat_exec", 32'(bus.ExecCount), 32'(CMAX));
    tick;
    chk("sat_hold", 32'(bus.ExecCount), 32'(CMAX));

    set_in(0, 0, 4'h0, 2'b00, 4'h0, 0, 0, 0);
    tick; tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
